select_in: RTL

Steering demultiplexer: one upstream PipeIn stream is routed to exactly one of `funnelWidth` downstream PipeIn consumers. The destination is chosen by a `select` method call. The block sits on the producer side of a funnel, with upstream logic enqueuing into a single port. A one-entry output register decouples upstream from the selected consumer. Each item carries the destination index latched at accept time, so retargeting never misroutes in-flight data.

---
 rtl/select_in_pkg.sv | 16 +
 rtl/select_in_decode.sv | 29 ++
 rtl/select_in.sv | 100 ++++++++++
 3 files changed

// File: rtl/select_in_pkg.sv
// select_in_pkg
// Shared constants and helpers for the select_in steering demultiplexer.
// The destination index is INDEX_W bits wide, which caps the funnel at
// MAX_FUNNEL consumers.
package select_in_pkg;

    localparam int INDEX_W    = 4;
    localparam int MAX_FUNNEL = 1 << INDEX_W;

    // True when idx addresses an existing consumer of an n-wide funnel.
    function automatic logic index_in_range(input logic [INDEX_W-1:0] idx,
                                            input int unsigned        n);
        return (32'(idx) < n);
    endfunction

endpackage

// File: rtl/select_in_decode.sv
// select_decode
// One-hot decode of the held item's destination, qualified by the output
// register being occupied.  The top level ANDs each bit with the matching
// consumer ready to form the per-port enables and the drain condition.
//
// Ports:
//   dest  in   destination index of the held item
//   full  in   output register occupied
//   sel   out  one-hot port select, all zero when the register is empty
module select_decode
    import select_in_pkg::*;
#(
    parameter int funnel_width = 8
) (
    input  logic [INDEX_W-1:0]      dest,
    input  logic                    full,
    output logic [funnel_width-1:0] sel
);

    always_comb begin
        sel = '0;
        for (int i = 0; i < funnel_width; i++) begin
            if (full && (dest == INDEX_W'(i))) begin
                sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/select_in.sv
// select_in
// Steering demultiplexer: a single upstream enqueue stream is routed to one
// of funnel_width downstream consumers.  The destination is set with the
// select method and latched with each item at accept time, so a later
// select never redirects an item already held in the output register.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   nrst         in   synchronous active-low reset
//   select_ena   in   set destination index
//   select_v     in   new index, only bits [3:0] are used
//   select_rdy   out  always 1
//   in_enq_ena   in   upstream enqueue strobe
//   in_enq_v     in   upstream payload
//   in_enq_rdy   out  upstream may enqueue this cycle
//   out_enq_ena  out  per-consumer enqueue strobe
//   out_enq_v    out  per-consumer payload (valid only with its strobe)
//   out_enq_rdy  in   per-consumer ready
module select_in
    import select_in_pkg::*;
#(
    parameter int funnel_width = 8,
    parameter int width        = 16
) (
    input  logic                                clk,
    input  logic                                nrst,
    input  logic                                select_ena,
    input  logic [31:0]                         select_v,
    output logic                                select_rdy,
    input  logic                                in_enq_ena,
    input  logic [width-1:0]                    in_enq_v,
    output logic                                in_enq_rdy,
    output logic [funnel_width-1:0]             out_enq_ena,
    output logic [funnel_width-1:0][width-1:0]  out_enq_v,
    input  logic [funnel_width-1:0]             out_enq_rdy
);

    logic [INDEX_W-1:0]      index;
    logic                    index_valid;
    logic                    full;
    logic [width-1:0]        data;
    logic [INDEX_W-1:0]      dest;

    logic [funnel_width-1:0] sel;
    logic                    drain;
    logic                    accept;

    // Upper select bits are architecturally ignored.
    logic unused_select_bits;
    assign unused_select_bits = ^select_v[31:INDEX_W];

    select_decode #(
        .funnel_width (funnel_width)
    ) u_decode (
        .dest (dest),
        .full (full),
        .sel  (sel)
    );

    for (genvar i = 0; i < funnel_width; i++) begin : g_out
        assign out_enq_ena[i] = sel[i] & out_enq_rdy[i];
        assign out_enq_v[i]   = data;
    end

    assign drain      = |out_enq_ena;
    assign select_rdy = 1'b1;

    // Draining and refilling in the same cycle keeps one item per cycle
    // flowing while the destination stays ready.
    assign in_enq_rdy = index_valid && (!full || drain);
    assign accept     = in_enq_ena && in_enq_rdy;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            index       <= '0;
            index_valid <= 1'b0;
            full        <= 1'b0;
        end else begin
            if (select_ena) begin
                index       <= select_v[INDEX_W-1:0];
                index_valid <= index_in_range(select_v[INDEX_W-1:0], funnel_width);
            end
            if (accept) begin
                full <= 1'b1;
            end else if (drain) begin
                full <= 1'b0;
            end
        end
    end

    // Payload and destination only matter while full is set, so they carry
    // no reset.  dest takes the index from before any same-cycle select.
    always_ff @(posedge clk) begin
        if (accept) begin
            data <= in_enq_v;
            dest <= index;
        end
    end

endmodule
